hms_time_core: RTL and testbench
================================

Name: hms_time_core

Overview:
Timekeeping core for the seven-segment clock. Counts seconds, minutes and hours from the 1 Hz NCO clock, and supports a button-driven set mode. Its sec/min/hour values feed the two-digit splitters and decoders, and its blink mask feeds the six-digit display multiplexer. It sits directly upstream of the digit-split/decode/display path and replaces the free-running 0~59 counter.

Parameters:
HOUR_MAX, 23, last hour value before wrap to 0 (legal values 11..23)

Ports:
clk  input  1  system clock, 50 MHz
rst_n  input  1  asynchronous active-low reset
i_tick  input  1  1 Hz 50%-duty clock from nco; sampled as data on clk; counting happens on its rising edge
i_sw_mode  input  1  debounced, clk-synchronous level; rising edge toggles RUN/SET
i_sw_pos  input  1  debounced level; rising edge selects next field in SET
i_sw_inc  input  1  debounced level; rising edge increments selected field in SET
o_sec  output  6  seconds, 0..59
o_min  output  6  minutes, 0..59
o_hour  output  6  hours, 0..HOUR_MAX
o_set_mode  output  1  1 while in SET
o_blink_enb  output  6  digit blank mask, bit0 = rightmost digit; 1 = blank that digit
o_day_pulse  output  1  one-clk pulse when HOUR_MAX:59:59 wraps to 00:00:00

Behaviour:
- Reset (async, rst_n = 0): o_sec/o_min/o_hour = 0, state RUN, pos = 0, blink phase = 0, o_set_mode = 0, o_blink_enb = 0, o_day_pulse = 0. All edge-detect history registers are cleared to 0.
  - Consequence: an input that is already high at reset release produces one edge on the first clk.
- Edge detection: one history flop per input. rise = in & ~hist.
  - A held level gives exactly one event.
  - Outputs update on the same clk edge at which rise is true (registered; one clk after the input is first seen high).
- States: RUN (0), SET (1).
- Priority among same-cycle button events: mode > pos > inc. Lower-priority events in that cycle are dropped.
- RUN:
  - tick rise: sec + 1.
  - sec = 59 → sec = 0, min + 1.
  - min = 59 with that carry → min = 0, hour + 1.
  - hour = HOUR_MAX with that carry → hour = 0, o_day_pulse = 1 for that one clk.
  - pos/inc rises are ignored.
  - mode rise: go to SET, pos = 0 (sec). A tick rise in the same cycle is still applied, because the tick acts on the current state.
- SET:
  - Time is frozen; tick rise only toggles the blink phase.
  - pos rise: pos cycles 0 (sec) → 1 (min) → 2 (hour) → 0.
  - inc rise: the selected field +1, wrapping independently. sec 59 → 0, min 59 → 0, hour HOUR_MAX → 0. No carry into the next field; o_day_pulse stays 0.
  - mode rise: go to RUN, blink phase = 0. A same-cycle tick is ignored; counting resumes on the next tick rise.
- o_blink_enb:
  - SET with blink phase = 1: 6'b000011 << (2*pos), giving 000011, 001100 or 110000.
  - Otherwise: 0.
- Arithmetic: 6-bit unsigned. Comparisons are >= against the max value, so a corrupted out-of-range value wraps to 0 on its next increment.
- Reset mid-operation, including mid-SET: immediate return to the reset values above.

Decomposition:
- Shared package/header:
  - state encodings ST_RUN/ST_SET
  - field indices POS_SEC = 0, POS_MIN = 1, POS_HOUR = 2
  - constants SEC_MAX = 59, MIN_MAX = 59
  - digit-pair mask base 6'b000011
- One sub-module: rise_det (clk, rst_n, i_lvl, o_rise). Instantiated four times, for tick, mode, pos and inc.
- Field counters and the FSM stay in the top module.

Test Plan:
- Async reset: run to 00:00:37, pulse rst_n low between clk edges → all outputs 0 immediately, before the next clk. After release, counting restarts from 00:00:00.
- Minute/hour carry:
  - 60 tick rises from reset → 00:01:00; o_min changes on the same clk as o_sec 59→0.
  - 3600 rises → 01:00:00.
- Day wrap: set 23:59:59 via SET, return to RUN, one tick rise → 00:00:00 and o_day_pulse high for exactly one clk. Repeat with HOUR_MAX = 11 from 11:59:59.
- Set mode:
  - Sequence: mode, pos, pos, then 25 inc rises.
  - Expected: hour = 1 (0 + 25 mod 24), sec/min unchanged while 10 ticks arrive.
  - o_blink_enb alternates 6'b110000 / 6'b000000 on successive tick rises; o_set_mode = 1.
- Priority:
  - In SET, mode+inc in the same clk → RUN, no increment.
  - pos+inc in the same clk → pos advances, value unchanged.
  - In RUN, mode+tick in the same clk → sec incremented and state SET.
- Held buttons: i_sw_inc held high for 1000 clks in SET → exactly one increment. i_sw_pos held across a mode toggle → no extra pos change.

Source files
------------

// File: rtl/hms_time_core_pkg.sv
// -----------------------------------------------------------------------------
// hms_time_core_pkg
// Shared definitions for the hours/minutes/seconds timekeeping core:
//   - state_t      : RUN / SET operating states
//   - POS_*        : field selector values used while setting the time
//   - SEC_MAX etc. : last legal value of each sixty-based field
//   - BLINK_BASE   : two-digit blank mask for the rightmost digit pair
//   - wrap_inc     : increment that wraps to 0 once the max is reached
//   - next_pos     : rotates the field selector sec -> min -> hour -> sec
// -----------------------------------------------------------------------------
package hms_time_core_pkg;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_SET = 1'b1
    } state_t;

    localparam logic [1:0] POS_SEC  = 2'd0;
    localparam logic [1:0] POS_MIN  = 2'd1;
    localparam logic [1:0] POS_HOUR = 2'd2;

    localparam logic [5:0] SEC_MAX    = 6'd59;
    localparam logic [5:0] MIN_MAX    = 6'd59;
    localparam logic [5:0] BLINK_BASE = 6'b000011;

    // Using >= rather than == means a corrupted out-of-range value
    // recovers to 0 on its next increment instead of running on to 63.
    function automatic logic [5:0] wrap_inc(input logic [5:0] value,
                                            input logic [5:0] max_value);
        return (value >= max_value) ? 6'd0 : value + 6'd1;
    endfunction

    function automatic logic [1:0] next_pos(input logic [1:0] pos);
        return (pos >= POS_HOUR) ? POS_SEC : pos + 2'd1;
    endfunction

endpackage

// File: rtl/hms_time_core_rise_det.sv
// -----------------------------------------------------------------------------
// rise_det
// Single-flop rising-edge detector for an already clk-synchronous level.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset, clears the history flop
//   i_lvl  : input level
//   o_rise : high for the clk in which i_lvl is high and was low last clk
// The history flop resets to 0, so a level already high at reset release
// reports one rise on the first clk.
// -----------------------------------------------------------------------------
module rise_det (
    input  logic clk,
    input  logic rst_n,
    input  logic i_lvl,
    output logic o_rise
);

    logic hist;

    // Remember last clk's level so a held input yields a single event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= 1'b0;
        end else begin
            hist <= i_lvl;
        end
    end

    assign o_rise = i_lvl & ~hist;

endmodule

// File: rtl/hms_time_core.sv
// -----------------------------------------------------------------------------
// hms_time_core
// Seconds/minutes/hours timekeeper with a button-driven set mode.
//   clk          : system clock (50 MHz)
//   rst_n        : asynchronous active-low reset
//   i_tick       : 1 Hz square wave, counted on its rising edge
//   i_sw_mode    : rising edge toggles RUN / SET
//   i_sw_pos     : rising edge selects the next field while in SET
//   i_sw_inc     : rising edge increments the selected field while in SET
//   o_sec/o_min  : 0..59
//   o_hour       : 0..HOUR_MAX
//   o_set_mode   : high while in SET
//   o_blink_enb  : per-digit blank mask (bit0 = rightmost digit)
//   o_day_pulse  : one-clk pulse when HOUR_MAX:59:59 rolls to 00:00:00
// -----------------------------------------------------------------------------
module hms_time_core
    import hms_time_core_pkg::*;
#(
    parameter int HOUR_MAX = 23
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_tick,
    input  logic       i_sw_mode,
    input  logic       i_sw_pos,
    input  logic       i_sw_inc,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic [5:0] o_hour,
    output logic       o_set_mode,
    output logic [5:0] o_blink_enb,
    output logic       o_day_pulse
);

    localparam logic [5:0] HOUR_MAX_V = 6'(HOUR_MAX);

    logic tick_rise, mode_rise, pos_rise, inc_rise;

    state_t     state_q, state_nxt;
    logic [5:0] sec_q, sec_nxt;
    logic [5:0] min_q, min_nxt;
    logic [5:0] hour_q, hour_nxt;
    logic [1:0] pos_q, pos_nxt;
    logic       blink_q, blink_nxt;
    logic       day_q, day_nxt;

    rise_det u_tick_rise (.clk(clk), .rst_n(rst_n), .i_lvl(i_tick),    .o_rise(tick_rise));
    rise_det u_mode_rise (.clk(clk), .rst_n(rst_n), .i_lvl(i_sw_mode), .o_rise(mode_rise));
    rise_det u_pos_rise  (.clk(clk), .rst_n(rst_n), .i_lvl(i_sw_pos),  .o_rise(pos_rise));
    rise_det u_inc_rise  (.clk(clk), .rst_n(rst_n), .i_lvl(i_sw_inc),  .o_rise(inc_rise));

    // All time, selector and mode state lives in one register bank so the
    // whole core returns to 00:00:00 RUN the instant rst_n drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            sec_q   <= 6'd0;
            min_q   <= 6'd0;
            hour_q  <= 6'd0;
            pos_q   <= POS_SEC;
            blink_q <= 1'b0;
            day_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            sec_q   <= sec_nxt;
            min_q   <= min_nxt;
            hour_q  <= hour_nxt;
            pos_q   <= pos_nxt;
            blink_q <= blink_nxt;
            day_q   <= day_nxt;
        end
    end

    // In RUN the tick acts on the current state before a mode change is
    // taken, so a simultaneous tick and mode press still counts. In SET the
    // button events are mutually exclusive with mode winning over pos over
    // inc, and leaving SET clears the blink phase so the display comes back
    // fully lit.
    always_comb begin
        state_nxt = state_q;
        sec_nxt   = sec_q;
        min_nxt   = min_q;
        hour_nxt  = hour_q;
        pos_nxt   = pos_q;
        blink_nxt = blink_q;
        day_nxt   = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (tick_rise) begin
                    sec_nxt = wrap_inc(sec_q, SEC_MAX);
                    if (sec_q >= SEC_MAX) begin
                        min_nxt = wrap_inc(min_q, MIN_MAX);
                        if (min_q >= MIN_MAX) begin
                            hour_nxt = wrap_inc(hour_q, HOUR_MAX_V);
                            if (hour_q >= HOUR_MAX_V) begin
                                day_nxt = 1'b1;
                            end
                        end
                    end
                end
                if (mode_rise) begin
                    state_nxt = ST_SET;
                    pos_nxt   = POS_SEC;
                end
            end

            ST_SET: begin
                if (tick_rise) begin
                    blink_nxt = ~blink_q;
                end
                if (mode_rise) begin
                    state_nxt = ST_RUN;
                    blink_nxt = 1'b0;
                end else if (pos_rise) begin
                    pos_nxt = next_pos(pos_q);
                end else if (inc_rise) begin
                    case (pos_q)
                        POS_SEC:  sec_nxt  = wrap_inc(sec_q, SEC_MAX);
                        POS_MIN:  min_nxt  = wrap_inc(min_q, MIN_MAX);
                        default:  hour_nxt = wrap_inc(hour_q, HOUR_MAX_V);
                    endcase
                end
            end

            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    assign o_sec       = sec_q;
    assign o_min       = min_q;
    assign o_hour      = hour_q;
    assign o_set_mode  = (state_q == ST_SET);
    assign o_day_pulse = day_q;
    // Shift the two-digit base mask by two digits per field position.
    assign o_blink_enb = (state_q == ST_SET && blink_q) ? (BLINK_BASE << {pos_q, 1'b0}) : 6'd0;

endmodule

// File: tb/tb_hms_time_core.sv
// -----------------------------------------------------------------------------
// tb_hms_time_core
// Drives two cores (HOUR_MAX = 23 and HOUR_MAX = 11) from the same inputs and
// compares both against a reference model that keeps the time as a running
// count of seconds and applies the button rules directly.
// -----------------------------------------------------------------------------
module tb_hms_time_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick, sw_mode, sw_pos, sw_inc;
    logic [5:0] o_sec [2];
    logic [5:0] o_min [2];
    logic [5:0] o_hour [2];
    logic [5:0] o_blink [2];
    logic       o_set [2];
    logic       o_day [2];

    int checks = 0;
    int errors = 0;

    // Reference model state, one entry per instance.
    int hmax [2] = '{23, 11};
    int m_s [2], m_m [2], m_h [2], m_pos [2];
    bit m_set [2], m_blink [2], m_day [2];
    bit p_tick, p_mode, p_pos, p_inc;

    always #10 clk = ~clk;

    hms_time_core #(.HOUR_MAX(23)) dut0 (
        .clk(clk), .rst_n(rst_n), .i_tick(tick), .i_sw_mode(sw_mode),
        .i_sw_pos(sw_pos), .i_sw_inc(sw_inc), .o_sec(o_sec[0]), .o_min(o_min[0]),
        .o_hour(o_hour[0]), .o_set_mode(o_set[0]), .o_blink_enb(o_blink[0]),
        .o_day_pulse(o_day[0])
    );

    hms_time_core #(.HOUR_MAX(11)) dut1 (
        .clk(clk), .rst_n(rst_n), .i_tick(tick), .i_sw_mode(sw_mode),
        .i_sw_pos(sw_pos), .i_sw_inc(sw_inc), .o_sec(o_sec[1]), .o_min(o_min[1]),
        .o_hour(o_hour[1]), .o_set_mode(o_set[1]), .o_blink_enb(o_blink[1]),
        .o_day_pulse(o_day[1])
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0d expected=%0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_s[i] = 0; m_m[i] = 0; m_h[i] = 0; m_pos[i] = 0;
            m_set[i] = 0; m_blink[i] = 0; m_day[i] = 0;
        end
        p_tick = 0; p_mode = 0; p_pos = 0; p_inc = 0;
    endtask

    // One clk of behaviour: time as total seconds in RUN, field-wise
    // modulo arithmetic in SET.
    task automatic model_step(input bit t, input bit mo, input bit po, input bit inc);
        bit tr = t & ~p_tick;
        bit mr = mo & ~p_mode;
        bit pr = po & ~p_pos;
        bit ir = inc & ~p_inc;
        for (int i = 0; i < 2; i++) begin
            int total;
            m_day[i] = 0;
            if (!m_set[i]) begin
                if (tr) begin
                    total = m_h[i] * 3600 + m_m[i] * 60 + m_s[i] + 1;
                    if (total >= (hmax[i] + 1) * 3600) begin
                        total = 0;
                        m_day[i] = 1;
                    end
                    m_h[i] = total / 3600;
                    m_m[i] = (total / 60) % 60;
                    m_s[i] = total % 60;
                end
                if (mr) begin
                    m_set[i] = 1;
                    m_pos[i] = 0;
                end
            end else begin
                if (tr) m_blink[i] = ~m_blink[i];
                if (mr) begin
                    m_set[i] = 0;
                    m_blink[i] = 0;
                end else if (pr) begin
                    m_pos[i] = (m_pos[i] + 1) % 3;
                end else if (ir) begin
                    case (m_pos[i])
                        0: m_s[i] = (m_s[i] + 1) % 60;
                        1: m_m[i] = (m_m[i] + 1) % 60;
                        default: m_h[i] = (m_h[i] + 1) % (hmax[i] + 1);
                    endcase
                end
            end
        end
        p_tick = t; p_mode = mo; p_pos = po; p_inc = inc;
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            int exp_blink = (m_set[i] && m_blink[i]) ? (3 << (2 * m_pos[i])) : 0;
            checkOutput($sformatf("sec[%0d]", i),   32'(o_sec[i]),   32'(m_s[i]));
            checkOutput($sformatf("min[%0d]", i),   32'(o_min[i]),   32'(m_m[i]));
            checkOutput($sformatf("hour[%0d]", i),  32'(o_hour[i]),  32'(m_h[i]));
            checkOutput($sformatf("set[%0d]", i),   32'(o_set[i]),   32'(m_set[i]));
            checkOutput($sformatf("blink[%0d]", i), 32'(o_blink[i]), 32'(exp_blink));
            checkOutput($sformatf("day[%0d]", i),   32'(o_day[i]),   32'(m_day[i]));
        end
    endtask

    // Called at a falling edge; drives levels, steps the model, checks
    // just after the next rising edge and returns at the following fall.
    task automatic applyStimulus(input bit t, input bit mo, input bit po, input bit inc);
        tick = t; sw_mode = mo; sw_pos = po; sw_inc = inc;
        model_step(t, mo, po, inc);
        @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic tick_rise();
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
    endtask

    task automatic press(input bit mo, input bit po, input bit inc);
        applyStimulus(0, mo, po, inc);
        applyStimulus(0, 0, 0, 0);
    endtask

    // Drops rst_n between edges and checks the outputs clear before any clk.
    task automatic do_reset();
        #3 rst_n = 1'b0;
        tick = 0; sw_mode = 0; sw_pos = 0; sw_inc = 0;
        #1;
        for (int i = 0; i < 2; i++) begin
            checkOutput("rst_sec",   32'(o_sec[i]),   32'd0);
            checkOutput("rst_min",   32'(o_min[i]),   32'd0);
            checkOutput("rst_hour",  32'(o_hour[i]),  32'd0);
            checkOutput("rst_set",   32'(o_set[i]),   32'd0);
            checkOutput("rst_blink", 32'(o_blink[i]), 32'd0);
            checkOutput("rst_day",   32'(o_day[i]),   32'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        bit tl;
        rst_n = 1'b1;
        tick = 0; sw_mode = 0; sw_pos = 0; sw_inc = 0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Count to 00:00:37, then reset asynchronously and restart.
        repeat (37) tick_rise();
        checkOutput("sec37", 32'(o_sec[0]), 32'd37);
        do_reset();

        // Minute and hour carries.
        repeat (60) tick_rise();
        checkOutput("min1_sec", 32'(o_sec[0]), 32'd0);
        checkOutput("min1_min", 32'(o_min[0]), 32'd1);
        repeat (3540) tick_rise();
        checkOutput("hour1_hour", 32'(o_hour[0]), 32'd1);
        checkOutput("hour1_min",  32'(o_min[0]),  32'd0);
        checkOutput("hour1_sec",  32'(o_sec[0]),  32'd0);

        // Set mode: select hour, 25 increments wrap through HOUR_MAX.
        do_reset();
        press(1, 0, 0);
        press(0, 1, 0);
        press(0, 1, 0);
        repeat (25) press(0, 0, 1);
        checkOutput("set_hour0", 32'(o_hour[0]), 32'd1);
        checkOutput("set_hour1", 32'(o_hour[1]), 32'd1);
        checkOutput("set_mode",  32'(o_set[0]),  32'd1);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1, 0, 0, 0);
            checkOutput("blink_hour", 32'(o_blink[0]), (k % 2 == 0) ? 32'b110000 : 32'd0);
            applyStimulus(0, 0, 0, 0);
        end
        checkOutput("frozen_sec", 32'(o_sec[0]), 32'd0);
        checkOutput("frozen_min", 32'(o_min[0]), 32'd0);

        // Held inc gives one increment.
        repeat (1000) applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("held_inc", 32'(o_hour[0]), 32'd2);

        // pos + inc together: pos wins, value untouched.
        press(0, 1, 1);
        checkOutput("posinc_hour", 32'(o_hour[0]), 32'd2);
        checkOutput("posinc_sec",  32'(o_sec[0]),  32'd0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("blink_sec", 32'(o_blink[0]), 32'b000011);
        applyStimulus(0, 0, 0, 0);

        // mode + inc together: back to RUN, no increment.
        press(1, 0, 1);
        checkOutput("modeinc_set", 32'(o_set[0]), 32'd0);
        checkOutput("modeinc_sec", 32'(o_sec[0]), 32'd0);

        // pos held across a mode toggle causes no extra pos change.
        repeat (3) applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 1, 1, 0);
        repeat (3) applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("heldpos_blink", 32'(o_blink[0]), 32'b000011);
        applyStimulus(0, 0, 0, 0);

        // Back to RUN, then mode + tick together: counts and enters SET.
        press(1, 0, 0);
        applyStimulus(1, 1, 0, 0);
        checkOutput("modetick_sec", 32'(o_sec[0]), 32'd1);
        checkOutput("modetick_set", 32'(o_set[0]), 32'd1);
        applyStimulus(0, 0, 0, 0);

        // Day wrap for both HOUR_MAX values: 23 hour incs lands on 23 / 11.
        do_reset();
        press(1, 0, 0);
        repeat (59) press(0, 0, 1);
        press(0, 1, 0);
        repeat (59) press(0, 0, 1);
        press(0, 1, 0);
        repeat (23) press(0, 0, 1);
        press(1, 0, 0);
        checkOutput("pre_hour0", 32'(o_hour[0]), 32'd23);
        checkOutput("pre_hour1", 32'(o_hour[1]), 32'd11);
        checkOutput("pre_min",   32'(o_min[1]),  32'd59);
        checkOutput("pre_sec",   32'(o_sec[1]),  32'd59);
        applyStimulus(1, 0, 0, 0);
        checkOutput("wrap_day0",  32'(o_day[0]),  32'd1);
        checkOutput("wrap_day1",  32'(o_day[1]),  32'd1);
        checkOutput("wrap_hour0", 32'(o_hour[0]), 32'd0);
        checkOutput("wrap_hour1", 32'(o_hour[1]), 32'd0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("post_day0", 32'(o_day[0]), 32'd0);
        checkOutput("post_day1", 32'(o_day[1]), 32'd0);

        // Random mix of ticks and button levels against the model.
        tl = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) tl = ~tl;
            applyStimulus(tl, $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                          $urandom_range(0, 3) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
